activation_writeback: RTL and testbench
=======================================

ACTIVATION_WRITEBACK -- requirements
Module: activation_writeback

Interface
REQ-001 Parameter: DATA_W, default 8, width of MAC result and neuron RAM data.
REQ-002 Parameter: ADDR_W, default 8, neuron RAM address width.
REQ-003 Parameter: FIFO_DEPTH, default 4, write-back buffer entries (power of two, >=2).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  MAC result available (neuron-finished pulse, delayed to align with data).
REQ-007 in_data  input  DATA_W  signed two's-complement MAC result.
REQ-008 in_addr  input  ADDR_W  neuron RAM write address for in_data.
REQ-009 in_ready  output  1  high when the FIFO can accept a push this cycle.
REQ-010 layer_start  input  1  one-cycle pulse; latches layer_nk and starts the layer count.
REQ-011 layer_nk  input  8  number of neurons in the layer to be written.
REQ-012 stall  input  1  neuron RAM write port busy; no write issued while high.
REQ-013 wre  output  1  neuron RAM write enable, registered.
REQ-014 write_address  output  ADDR_W  neuron RAM write address, registered.
REQ-015 write_data  output  DATA_W  activated value, registered.
REQ-016 layer_done  output  1  one-cycle pulse when layer_nk writes have completed.
REQ-017 overflow  output  1  sticky; set when a push arrives while full.

Function
REQ-018 FIFO SHALL store {activated data, addr}; activation is applied at push, before storage.
REQ-019 in_ready SHALL equal NOT full, derived from the current occupancy count only; a same-cycle pop does not free space.
REQ-020 Push when in_valid && in_ready; in_valid && !in_ready SHALL drop the item and set overflow.
REQ-021 Pop when FIFO non-empty && !stall; the popped entry SHALL appear on write_data/write_address with wre=1 in the next cycle.
REQ-022 Latency SHALL be one cycle: push into an empty FIFO at edge N with stall low gives wre=1 after edge N+1.
REQ-023 wre SHALL be 0 in any cycle following a no-pop cycle; write_data/write_address hold their last values when wre=0.
REQ-024 Simultaneous push and pop SHALL leave the occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-025 FSM states: IDLE, ACTIVE, DONE.
REQ-026 IDLE -> ACTIVE on layer_start with layer_nk != 0; IDLE -> DONE on layer_start with layer_nk == 0.
REQ-027 In ACTIVE, an 8-bit write counter SHALL increment per issued write (wre=1); when it reaches the latched nk, go to DONE.
REQ-028 DONE SHALL assert layer_done for exactly one cycle, then return to IDLE.
REQ-029 A layer_start in ACTIVE or DONE SHALL relatch layer_nk, clear the counter, and enter ACTIVE (or DONE if nk=0); FIFO contents are retained.
REQ-030 Writes SHALL also drain in IDLE, but only writes issued in ACTIVE are counted.

Reset
REQ-031 On reset, FIFO SHALL be emptied, pointers, count and write counter zeroed, and FSM set to IDLE.
REQ-032 During and after reset: wre=0, write_data=0, write_address=0, layer_done=0, overflow=0, in_ready=1.
REQ-033 Reset mid-layer SHALL discard buffered entries without issuing writes; reset dominates all other inputs.

Configuration
REQ-034 Macro ACT_RELU_EN: when defined, values with in_data[DATA_W-1]=1 SHALL be stored as 0 (ReLU); when undefined, in_data SHALL be stored unchanged (linear).

Verification
REQ-035 Reset, then one push of in_data=8'hF6, addr=3 with stall=0 -> next cycle wre=1, addr=3, data=0x00 with ACT_RELU_EN, 0xF6 without.
REQ-036 layer_start with nk=3, then pushes 0x05, 0x7F, 0x10 on consecutive cycles -> three consecutive writes, then layer_done high for one cycle, FSM in IDLE.
REQ-037 stall=1, then 5 pushes with FIFO_DEPTH=4 -> in_ready low after the 4th push, 5th dropped, overflow=1; stall=0 -> 4 writes in push order.
REQ-038 layer_start with nk=0 -> layer_done pulse on the following cycle, no writes.
REQ-039 FIFO at 2 entries, push and pop in the same cycle repeated 8 times -> occupancy stays 2, data order preserved across pointer wrap.
REQ-040 Reset asserted with 3 entries buffered -> wre stays 0, in_ready=1, overflow=0, and no layer_done pulse.

Source files
------------

// File: rtl/activation_writeback.sv
// Activation write-back: buffers MAC results in a small FIFO and drains them to neuron RAM.
// Define ACT_RELU_EN to apply ReLU at push; otherwise values are stored unchanged (linear).
module activation_writeback #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              in_ready,
  input  logic              layer_start,
  input  logic [7:0]        layer_nk,
  input  logic              stall,
  output logic              wre,
  output logic [ADDR_W-1:0] write_address,
  output logic [DATA_W-1:0] write_data,
  output logic              layer_done,
  output logic              overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = DATA_W + ADDR_W;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  logic [ENT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              wre_q, wre_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] act_data;
  logic [ENT_W-1:0]  rd_entry;
  logic              full, push, pop;

  state_t            state_q, state_d;
  logic [7:0]        nk_q, nk_d;
  logic [7:0]        cnt_q, cnt_d;

  // Activation applied before storage
  always_comb begin
`ifdef ACT_RELU_EN
    act_data = in_data[DATA_W-1] ? '0 : in_data;
`else
    act_data = in_data;
`endif
  end

  // Full is judged from occupancy alone; a same-cycle pop does not free a slot
  assign full     = (count_q == CNT_W'(FIFO_DEPTH));
  assign in_ready = ~full;
  assign push     = in_valid & ~full;
  assign pop      = (count_q != '0) & ~stall;
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (in_valid & full);
    wre_d      = pop;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wdata_d  = rd_entry[ENT_W-1 -: DATA_W];
      waddr_d  = rd_entry[ADDR_W-1:0];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {act_data, in_addr};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wre_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wre_q      <= wre_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign wre           = wre_q;
  assign write_address = waddr_q;
  assign write_data    = wdata_q;
  assign overflow      = overflow_q;

  // Layer FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      nk_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      nk_q    <= nk_d;
      cnt_q   <= cnt_d;
    end
  end

  // Layer FSM: next state; only writes issued while ACTIVE are counted
  always_comb begin
    state_d = state_q;
    nk_d    = nk_q;
    cnt_d   = cnt_q;
    if (layer_start) begin
      nk_d    = layer_nk;
      cnt_d   = '0;
      state_d = (layer_nk == 8'd0) ? DONE : ACTIVE;
    end else begin
      case (state_q)
        ACTIVE: begin
          if (wre_q) begin
            cnt_d = cnt_q + 8'd1;
            if (8'(cnt_q + 8'd1) == nk_q) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Layer FSM: outputs
  always_comb begin
    layer_done = (state_q == DONE);
  end

endmodule

// File: tb/tb_activation_writeback.sv
// Directed bench for activation_writeback: vector table plus multi-cycle corner sequences.
module tb_activation_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_addr;
  logic       in_ready;
  logic       layer_start;
  logic [7:0] layer_nk;
  logic       stall;
  logic       wre;
  logic [7:0] write_address;
  logic [7:0] write_data;
  logic       layer_done;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

  activation_writeback #(.DATA_W(8), .ADDR_W(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_addr(in_addr),
    .in_ready(in_ready), .layer_start(layer_start), .layer_nk(layer_nk), .stall(stall),
    .wre(wre), .write_address(write_address), .write_data(write_data),
    .layer_done(layer_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [7:0] a;
    logic       st;
    logic       ls;
    logic [7:0] nk;
    logic       e_wre;
    logic [7:0] e_addr;
    logic [7:0] e_data;
    logic       e_rdy;
    logic       e_done;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [7:0] act(input logic [7:0] x);
`ifdef ACT_RELU_EN
    return x[7] ? 8'h00 : x;
`else
    return x;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic idle_in();
    in_valid    = 1'b0;
    in_data     = 8'h00;
    in_addr     = 8'h00;
    layer_start = 1'b0;
    layer_nk    = 8'd0;
  endtask

  task automatic chk_write(input string nm, input logic [7:0] a, input logic [7:0] d);
    chk({nm, " wre"}, 32'(wre), 32'd1);
    chk({nm, " addr"}, 32'(write_address), 32'(a));
    chk({nm, " data"}, 32'(write_data), 32'(d));
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, " wre"}, 32'(wre), 32'd0);
    chk({nm, " addr"}, 32'(write_address), 32'd0);
    chk({nm, " data"}, 32'(write_data), 32'd0);
    chk({nm, " done"}, 32'(layer_done), 32'd0);
    chk({nm, " ovf"}, 32'(overflow), 32'd0);
    chk({nm, " rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    // single write with activation, nk=3 layer, nk=0 layer
    vecs[0]  = '{1'b1, 8'hF6, 8'd3,  1'b0, 1'b0, 8'd0, 1'b0, 8'd0,  8'h00,      1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 8'h00, 8'd0,  1'b0, 1'b0, 8'd0, 1'b1, 8'd3,  act(8'hF6), 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 8'h00, 8'd0,  1'b0, 1'b1, 8'd3, 1'b0, 8'd3,  act(8'hF6), 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 8'h05, 8'd10, 1'b0, 1'b0, 8'd0, 1'b0, 8'd3,  act(8'hF6), 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 8'h7F, 8'd11, 1'b0, 1'b0, 8'd0, 1'b1, 8'd10, 8'h05,      1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 8'h10, 8'd12, 1'b0, 1'b0, 8'd0, 1'b1, 8'd11, 8'h7F,      1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 8'h00, 8'd0,  1'b0, 1'b0, 8'd0, 1'b1, 8'd12, 8'h10,      1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'h00, 8'd0,  1'b0, 1'b0, 8'd0, 1'b0, 8'd12, 8'h10,      1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 8'h00, 8'd0,  1'b0, 1'b0, 8'd0, 1'b0, 8'd12, 8'h10,      1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 8'h00, 8'd0,  1'b0, 1'b1, 8'd0, 1'b0, 8'd12, 8'h10,      1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 8'h00, 8'd0,  1'b0, 1'b0, 8'd0, 1'b0, 8'd12, 8'h10,      1'b1, 1'b0, 1'b0};

    idle_in();
    stall = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk_reset_outs("in_reset");
    reset = 1'b0;
    tick();
    chk_reset_outs("post_reset");

    foreach (vecs[i]) begin
      in_valid    = vecs[i].v;
      in_data     = vecs[i].d;
      in_addr     = vecs[i].a;
      stall       = vecs[i].st;
      layer_start = vecs[i].ls;
      layer_nk    = vecs[i].nk;
      tick();
      chk($sformatf("vec%0d wre", i),  32'(wre),           32'(vecs[i].e_wre));
      chk($sformatf("vec%0d addr", i), 32'(write_address), 32'(vecs[i].e_addr));
      chk($sformatf("vec%0d data", i), 32'(write_data),    32'(vecs[i].e_data));
      chk($sformatf("vec%0d rdy", i),  32'(in_ready),      32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d done", i), 32'(layer_done),    32'(vecs[i].e_done));
      chk($sformatf("vec%0d ovf", i),  32'(overflow),      32'(vecs[i].e_ovf));
    end
    idle_in();

    // Stalled fill past capacity, then drain in order
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h11 + i);
      in_addr  = 8'(8'd20 + i);
      tick();
      chk($sformatf("ovfseq rdy%0d", i), 32'(in_ready), (i < 3) ? 32'd1 : 32'd0);
      chk($sformatf("ovfseq ovf%0d", i), 32'(overflow), (i == 4) ? 32'd1 : 32'd0);
      chk($sformatf("ovfseq wre%0d", i), 32'(wre), 32'd0);
    end
    idle_in();
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_write($sformatf("drain%0d", k), 8'(8'd20 + k), 8'(8'h11 + k));
    end
    tick();
    chk("drain end wre", 32'(wre), 32'd0);
    chk("drain end rdy", 32'(in_ready), 32'd1);
    chk("drain ovf sticky", 32'(overflow), 32'd1);
    reset = 1'b1;
    tick();
    chk_reset_outs("ovf_clear");
    reset = 1'b0;
    tick();

    // Steady push+pop at two entries across pointer wrap
    stall    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h30; in_addr = 8'd40; tick();
    in_data  = 8'h31; in_addr = 8'd41; tick();
    stall = 1'b0;
    for (int k = 0; k < 8; k++) begin
      in_data = 8'(8'h32 + k);
      in_addr = 8'(8'd42 + k);
      tick();
      chk_write($sformatf("wrap%0d", k), 8'(8'd40 + k), 8'(8'h30 + k));
      chk($sformatf("wrap%0d occ", k), 32'(dut.count_q), 32'd2);
      chk($sformatf("wrap%0d rdy", k), 32'(in_ready), 32'd1);
    end
    idle_in();
    tick();
    chk_write("wrap_tail0", 8'd48, 8'h38);
    tick();
    chk_write("wrap_tail1", 8'd49, 8'h39);
    tick();
    chk("wrap end wre", 32'(wre), 32'd0);

    // Reset mid-layer with three buffered entries
    layer_start = 1'b1;
    layer_nk    = 8'd3;
    tick();
    idle_in();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h50 + i);
      in_addr  = 8'(8'd60 + i);
      tick();
    end
    chk("midlayer rdy", 32'(in_ready), 32'd1);
    chk("midlayer wre", 32'(wre), 32'd0);
    stall    = 1'b0;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h66;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_reset_outs($sformatf("midrst%0d", i));
    end
    reset = 1'b0;
    idle_in();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("after_rst%0d wre", i), 32'(wre), 32'd0);
      chk($sformatf("after_rst%0d done", i), 32'(layer_done), 32'd0);
      chk($sformatf("after_rst%0d rdy", i), 32'(in_ready), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
